net_node_n: RTL and testbench



---
 rtl/nmos_enc_pkg.sv | 17 +
 rtl/net_node_n_if.sv | 25 ++
 rtl/net_resolve.sv | 30 +++
 rtl/net_node_n.sv | 73 +++++++
 tb/tb_net_node_n.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/nmos_enc_pkg.sv
// rtl/nmos_enc_pkg.sv - drive-code encoding shared by the NMOS net, pad and transistor models
package nmos_enc_pkg;

    localparam int W = 2;

    typedef logic [W-1:0] enc_t;

    localparam enc_t ENC_Z = 2'b00;
    localparam enc_t ENC_0 = 2'b01;
    localparam enc_t ENC_1 = 2'b10;
    localparam enc_t ENC_X = 2'b11;

    function automatic logic is_legal_drive(input enc_t code);
        return (code == ENC_0) || (code == ENC_1);
    endfunction

endpackage

// File: rtl/net_node_n_if.sv
// rtl/net_node_n_if.sv - driver codes in, resolved net value and status flags out
interface net_node_n_if #(
    parameter int NIN = 2
);
    import nmos_enc_pkg::*;

    logic             en;
    logic [W*NIN-1:0] in;
    enc_t             out;
    logic             contention;
    logic             illegal;
    logic             floating;
    logic             changed;

    modport master (
        output en, in,
        input  out, contention, illegal, floating, changed
    );

    modport slave (
        input  en, in,
        output out, contention, illegal, floating, changed
    );

endinterface

// File: rtl/net_resolve.sv
// rtl/net_resolve.sv - combinational summary of every driver code attached to one net
module net_resolve
    import nmos_enc_pkg::*;
#(
    parameter int NIN = 2
) (
    input  logic [W*NIN-1:0] codes,
    output logic             any0,
    output logic             any1,
    output logic             anyx,
    output logic             none
);

    logic legal;

    always_comb begin
        any0  = 1'b0;
        any1  = 1'b0;
        anyx  = 1'b0;
        legal = 1'b0;
        for (int k = 0; k < NIN; k++) begin
            any0  = any0  | (codes[W*k +: W] == ENC_0);
            any1  = any1  | (codes[W*k +: W] == ENC_1);
            anyx  = anyx  | (codes[W*k +: W] == ENC_X);
            legal = legal | is_legal_drive(codes[W*k +: W]);
        end
        none = ~legal;
    end

endmodule

// File: rtl/net_node_n.sv
// rtl/net_node_n.sv - registered net resolver: pull-down dominance, charge retention with leakage
module net_node_n
    import nmos_enc_pkg::*;
#(
    parameter int   NIN       = 2,
    parameter int   DECAY     = 0,
    parameter enc_t DECAY_VAL = 2'b01,
    parameter enc_t RST_VAL   = 2'b01
) (
    input  logic         eclk,
    input  logic         erst,
    net_node_n_if.slave  bus
);

    localparam int CW = (DECAY == 0) ? 1 : $clog2(DECAY + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DECAY);

    logic          any0, any1, anyx, none;
    logic [CW-1:0] cnt, cnt_inc, cnt_nxt;
    enc_t          out_q, nxt;
    logic          contention_q, illegal_q, floating_q, changed_q;

    net_resolve #(.NIN(NIN)) u_resolve (
        .codes (bus.in),
        .any0  (any0),
        .any1  (any1),
        .anyx  (anyx),
        .none  (none)
    );

    always_comb begin
        cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        cnt_nxt = '0;
        nxt     = out_q;
        if (any0) begin
            nxt = ENC_0;
        end else if (any1) begin
            nxt = ENC_1;
        end else begin
            // Undriven: keep stored charge until the leakage count runs out
            cnt_nxt = cnt_inc;
            if ((DECAY != 0) && (cnt_inc == CNT_MAX))
                nxt = DECAY_VAL;
        end
    end

    always_ff @(posedge eclk or posedge erst) begin
        if (erst) begin
            out_q        <= RST_VAL;
            contention_q <= 1'b0;
            illegal_q    <= 1'b0;
            floating_q   <= 1'b0;
            changed_q    <= 1'b0;
            cnt          <= '0;
        end else if (bus.en) begin
            out_q        <= nxt;
            contention_q <= any0 & any1;
            illegal_q    <= anyx;
            floating_q   <= none;
            changed_q    <= (nxt != out_q);
            cnt          <= cnt_nxt;
        end else begin
            changed_q    <= 1'b0;
        end
    end

    assign bus.out        = out_q;
    assign bus.contention = contention_q;
    assign bus.illegal    = illegal_q;
    assign bus.floating   = floating_q;
    assign bus.changed    = changed_q;

endmodule

// File: tb/tb_net_node_n.sv
// tb/tb_net_node_n.sv - directed bench for net_node_n (four-input hold net and two-input leaky net)
module tb_net_node_n;
    import nmos_enc_pkg::*;

    logic eclk = 1'b0;
    logic erst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    always #5 eclk = ~eclk;

    net_node_n_if #(.NIN(4)) bus_a ();
    net_node_n_if #(.NIN(2)) bus_b ();

    net_node_n #(.NIN(4), .DECAY(0), .DECAY_VAL(2'b01), .RST_VAL(2'b01)) dut_a (
        .eclk (eclk),
        .erst (erst),
        .bus  (bus_a)
    );

    net_node_n #(.NIN(2), .DECAY(3), .DECAY_VAL(2'b01), .RST_VAL(2'b01)) dut_b (
        .eclk (eclk),
        .erst (erst),
        .bus  (bus_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge eclk);
        #1;
    endtask

    task automatic chk_a(input string tag, input enc_t o, input logic c, input logic i,
                         input logic f, input logic ch);
        chk({tag, "_a_out"},   8'(bus_a.out), 8'(o));
        chk({tag, "_a_cont"},  8'(bus_a.contention), 8'(c));
        chk({tag, "_a_ill"},   8'(bus_a.illegal), 8'(i));
        chk({tag, "_a_float"}, 8'(bus_a.floating), 8'(f));
        chk({tag, "_a_chg"},   8'(bus_a.changed), 8'(ch));
    endtask

    task automatic chk_b(input string tag, input enc_t o, input logic c, input logic i,
                         input logic f, input logic ch);
        chk({tag, "_b_out"},   8'(bus_b.out), 8'(o));
        chk({tag, "_b_cont"},  8'(bus_b.contention), 8'(c));
        chk({tag, "_b_ill"},   8'(bus_b.illegal), 8'(i));
        chk({tag, "_b_float"}, 8'(bus_b.floating), 8'(f));
        chk({tag, "_b_chg"},   8'(bus_b.changed), 8'(ch));
    endtask

    initial begin
        bus_a.en = 1'b0;
        bus_a.in = '0;
        bus_b.en = 1'b0;
        bus_b.in = '0;
        step();
        step();
        chk_a("rst", 2'b01, 0, 0, 0, 0);
        chk_b("rst", 2'b01, 0, 0, 0, 0);

        // Release, drive all 10, then hit reset asynchronously mid-cycle
        erst = 1'b0;
        bus_a.en = 1'b1;
        bus_a.in = 8'b10_10_10_10;
        step();
        chk_a("drv1", 2'b10, 0, 0, 0, 1);
        #2 erst = 1'b1;
        #1;
        chk_a("arst", 2'b01, 0, 0, 0, 0);
        #1 erst = 1'b0;
        step();
        chk_a("rel", 2'b10, 0, 0, 0, 1);

        // Contention: pull-down wins
        bus_a.in = 8'b10_00_01_10;
        step();
        chk_a("cont", 2'b01, 1, 0, 0, 1);
        step();
        chk_a("cont2", 2'b01, 1, 0, 0, 0);

        // Infinite charge retention
        bus_a.in = 8'b00_00_00_10;
        step();
        chk_a("hold0", 2'b10, 0, 0, 0, 1);
        bus_a.in = '0;
        for (int n = 0; n < 100; n++) begin
            step();
            chk_a("hold", 2'b10, 0, 0, 1, 0);
        end

        // Strobe gating
        bus_a.in = 8'b00_01_00_00;
        step();
        chk_a("gate0", 2'b01, 0, 0, 0, 1);
        bus_a.en = 1'b0;
        for (int n = 0; n < 10; n++) begin
            bus_a.in = n[0] ? 8'b10_10_10_10 : 8'b01_01_01_01;
            step();
            chk_a("gated", 2'b01, 0, 0, 0, 0);
        end
        bus_a.en = 1'b1;
        bus_a.in = 8'b10_10_10_10;
        step();
        chk_a("pulse", 2'b10, 0, 0, 0, 1);
        bus_a.en = 1'b0;
        step();
        chk_a("pulse_end", 2'b10, 0, 0, 0, 0);

        // Leakage on the DECAY=3 net
        bus_b.en = 1'b1;
        bus_b.in = 4'b10_10;
        step();
        chk_b("ldrv", 2'b10, 0, 0, 0, 1);
        bus_b.in = 4'b00_00;
        step();
        chk_b("leak1", 2'b10, 0, 0, 1, 0);
        step();
        chk_b("leak2", 2'b10, 0, 0, 1, 0);
        step();
        chk_b("leak3", 2'b01, 0, 0, 1, 1);
        step();
        chk_b("leak4", 2'b01, 0, 0, 1, 0);
        bus_b.in = 4'b10_00;
        step();
        chk_b("redrv", 2'b10, 0, 0, 0, 1);
        bus_b.in = 4'b00_00;
        step();
        chk_b("clr1", 2'b10, 0, 0, 1, 0);
        step();
        chk_b("clr2", 2'b10, 0, 0, 1, 0);

        // Illegal codes
        bus_b.in = 4'b00_10;
        step();
        chk_b("idrv", 2'b10, 0, 0, 0, 0);
        bus_b.in = 4'b11_00;
        step();
        chk_b("ill_z", 2'b10, 0, 1, 1, 0);
        bus_b.in = 4'b11_10;
        step();
        chk_b("ill_1", 2'b10, 0, 1, 0, 0);
        bus_b.in = 4'b01_11;
        step();
        chk_b("ill_0", 2'b01, 0, 1, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
